// File: rtl/scan_pkg.sv
// ---------------------------------------------------------------------------
// scan_pkg
// Shared definitions for the pulse-counter host sequencer: counter register
// map, the reset command byte, the sequencer state type and a helper that
// maps a result byte index (0..7) onto its counter register address.
// ---------------------------------------------------------------------------
package scan_pkg;

  localparam logic [7:0] CTR_ADDR_CMD   = 8'h26;
  localparam logic [7:0] CTR_ADDR_GATE  = 8'h27;
  localparam logic [7:0] CTR_CMD_RESET  = 8'h01;
  localparam logic [7:0] CTR_ADDR_NONE  = 8'h00;

  // Count and time registers are not contiguous: 8'h2A-8'h2F are unmapped.
  localparam logic [7:0] CTR_ADDR_DATA [4] = '{8'h28, 8'h29, 8'h30, 8'h31};
  localparam logic [7:0] CTR_ADDR_TIME [4] = '{8'h32, 8'h33, 8'h34, 8'h35};

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_RST_WR,
    ST_GAP,
    ST_CFG_WR,
    ST_GAP2,
    ST_START,
    ST_WAIT_LO,
    ST_WAIT_HI,
    ST_SNAP,
    ST_READ,
    ST_DONE,
    ST_ABORT_WR
  } ctrl_state_t;

  // Byte 0..3 -> count LSB..MSB, byte 4..7 -> time LSB..MSB.
  function automatic logic [7:0] ctr_read_addr(input logic [2:0] idx);
    if (idx[2]) return CTR_ADDR_TIME[idx[1:0]];
    else        return CTR_ADDR_DATA[idx[1:0]];
  endfunction

endpackage

// File: rtl/counter_scan_ctrl.sv
// ---------------------------------------------------------------------------
// counter_scan_ctrl
// Host-side sequencer for one pulse counter. Accepts a gate command, resets
// and programs the counter, pulses start, waits for the stop flag to fall and
// rise again, requests a snapshot, reads the 8 result bytes and hands
// {count,time} to the packet builder. Stuck runs time out; cmd_abort cancels.
//
// Ports
//   clk, rst_n                    clock, asynchronous active-low reset
//   cmd_valid/cmd_ready/cmd_gate  gate command handshake (gate in seconds)
//   cmd_abort                     level abort of the current run
//   bus_addr/bus_wdata/bus_we     counter register bus (all registered)
//   bus_rdata                     counter read data, 2-cycle latency
//   ctr_start/ctr_stop            start pulse / counter stop flag
//   ctr_read_open                 snapshot request, high through SNAP+READ
//   res_valid/res_ready           result handshake
//   res_count/res_time/res_timeout  result payload
//   busy                          sequencer not idle
// ---------------------------------------------------------------------------
module counter_scan_ctrl
  import scan_pkg::*;
#(
  parameter int          DATA_WIDTH  = 8,
  parameter logic [31:0] WAIT_LIMIT  = 32'd200_000_000,
  parameter int          SNAP_CYCLES = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [DATA_WIDTH-1:0]   cmd_gate,
  input  logic                    cmd_abort,
  output logic [DATA_WIDTH-1:0]   bus_addr,
  output logic [DATA_WIDTH-1:0]   bus_wdata,
  output logic                    bus_we,
  input  logic [DATA_WIDTH-1:0]   bus_rdata,
  output logic                    ctr_start,
  input  logic                    ctr_stop,
  output logic                    ctr_read_open,
  output logic                    res_valid,
  input  logic                    res_ready,
  output logic [4*DATA_WIDTH-1:0] res_count,
  output logic [4*DATA_WIDTH-1:0] res_time,
  output logic                    res_timeout,
  output logic                    busy
);

  localparam int RW = 4 * DATA_WIDTH;

  ctrl_state_t           state_q, state_d;
  logic [2:0]            byte_q, byte_d;
  logic [1:0]            lat_q, lat_d;
  logic [7:0]            phase_q, phase_d;
  logic [31:0]           tmo_q, tmo_d;
  logic [DATA_WIDTH-1:0] gate_q, gate_d;
  logic [RW-1:0]         count_q, count_d;
  logic [RW-1:0]         time_q, time_d;
  logic                  timeout_q, timeout_d;

  logic [DATA_WIDTH-1:0] bus_addr_q, bus_addr_d;
  logic [DATA_WIDTH-1:0] bus_wdata_q, bus_wdata_d;
  logic                  bus_we_q, bus_we_d;
  logic                  ctr_start_q, ctr_start_d;
  logic                  read_open_q, read_open_d;
  logic                  res_valid_q, res_valid_d;
  logic                  cmd_ready_q, cmd_ready_d;
  logic                  busy_q, busy_d;

  // Next-state and datapath
  always_comb begin
    state_d   = state_q;
    byte_d    = byte_q;
    lat_d     = lat_q;
    phase_d   = phase_q;
    tmo_d     = tmo_q;
    gate_d    = gate_q;
    count_d   = count_q;
    time_d    = time_q;
    timeout_d = timeout_q;

    case (state_q)
      ST_IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          gate_d    = cmd_gate;
          timeout_d = 1'b0;
          state_d   = ST_RST_WR;
        end
      end
      ST_RST_WR: begin
        phase_d = 8'd0;
        state_d = ST_GAP;
      end
      // Two idle cycles so the counter can self-clear its reset command.
      ST_GAP: begin
        if (phase_q == 8'd1) state_d = ST_CFG_WR;
        else                 phase_d = phase_q + 8'd1;
      end
      ST_CFG_WR: state_d = ST_GAP2;
      ST_GAP2:   state_d = ST_START;
      ST_START: begin
        tmo_d   = 32'd0;
        state_d = ST_WAIT_LO;
      end
      ST_WAIT_LO, ST_WAIT_HI: begin
        if (state_q == ST_WAIT_LO) begin
          // A zero-length gate drops stop for a single cycle only, which is
          // exactly the first WAIT_LO cycle.
          if (!ctr_stop) state_d = ST_WAIT_HI;
        end else if (ctr_stop) begin
          phase_d = 8'd0;
          state_d = ST_SNAP;
        end
        // tmo_q stays below WAIT_LIMIT here, so the increment cannot wrap.
        if (tmo_q >= WAIT_LIMIT) begin
          timeout_d = 1'b1;
          count_d   = '0;
          time_d    = '0;
          state_d   = ST_ABORT_WR;
        end else begin
          tmo_d = tmo_q + 32'd1;
        end
      end
      ST_SNAP: begin
        if (phase_q == 8'(SNAP_CYCLES - 1)) begin
          byte_d  = 3'd0;
          lat_d   = 2'd0;
          state_d = ST_READ;
        end else begin
          phase_d = phase_q + 8'd1;
        end
      end
      // Address goes out on the edge that enters lat 0; the counter
      // registers it one edge later; the byte is captured the edge after.
      ST_READ: begin
        if (lat_q == 2'd0) begin
          lat_d = 2'd1;
        end else begin
          lat_d = 2'd0;
          if (byte_q[2]) time_d[DATA_WIDTH*byte_q[1:0] +: DATA_WIDTH]  = bus_rdata;
          else           count_d[DATA_WIDTH*byte_q[1:0] +: DATA_WIDTH] = bus_rdata;
          if (byte_q == 3'd7) state_d = ST_DONE;
          else                byte_d  = byte_q + 3'd1;
        end
      end
      ST_DONE: begin
        if (res_valid_q && res_ready) state_d = ST_IDLE;
      end
      // Shared by timeout (which then reports) and abort (which does not).
      ST_ABORT_WR: begin
        if (timeout_q && !cmd_abort) state_d = ST_DONE;
        else begin
          timeout_d = 1'b0;
          state_d   = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Abort overrides any same-cycle transition, including a timeout.
    if (cmd_abort && !(state_q inside {ST_IDLE, ST_DONE, ST_ABORT_WR})) begin
      timeout_d = 1'b0;
      state_d   = ST_ABORT_WR;
    end
  end

  // Registered outputs are decoded from the state being entered.
  always_comb begin
    bus_addr_d  = CTR_ADDR_NONE;
    bus_wdata_d = '0;
    bus_we_d    = 1'b0;
    case (state_d)
      ST_RST_WR, ST_ABORT_WR: begin
        bus_addr_d  = CTR_ADDR_CMD;
        bus_wdata_d = CTR_CMD_RESET;
        bus_we_d    = 1'b1;
      end
      ST_CFG_WR: begin
        bus_addr_d  = CTR_ADDR_GATE;
        bus_wdata_d = gate_d;
        bus_we_d    = 1'b1;
      end
      ST_READ: bus_addr_d = ctr_read_addr(byte_d);
      default: ;
    endcase
    ctr_start_d = (state_d == ST_START);
    read_open_d = (state_d == ST_SNAP) || (state_d == ST_READ);
    res_valid_d = (state_d == ST_DONE);
    cmd_ready_d = (state_d == ST_IDLE);
    busy_d      = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      byte_q      <= '0;
      lat_q       <= '0;
      phase_q     <= '0;
      tmo_q       <= '0;
      gate_q      <= '0;
      count_q     <= '0;
      time_q      <= '0;
      timeout_q   <= 1'b0;
      bus_addr_q  <= CTR_ADDR_NONE;
      bus_wdata_q <= '0;
      bus_we_q    <= 1'b0;
      ctr_start_q <= 1'b0;
      read_open_q <= 1'b0;
      res_valid_q <= 1'b0;
      cmd_ready_q <= 1'b1;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      byte_q      <= byte_d;
      lat_q       <= lat_d;
      phase_q     <= phase_d;
      tmo_q       <= tmo_d;
      gate_q      <= gate_d;
      count_q     <= count_d;
      time_q      <= time_d;
      timeout_q   <= timeout_d;
      bus_addr_q  <= bus_addr_d;
      bus_wdata_q <= bus_wdata_d;
      bus_we_q    <= bus_we_d;
      ctr_start_q <= ctr_start_d;
      read_open_q <= read_open_d;
      res_valid_q <= res_valid_d;
      cmd_ready_q <= cmd_ready_d;
      busy_q      <= busy_d;
    end
  end

  assign bus_addr      = bus_addr_q;
  assign bus_wdata     = bus_wdata_q;
  assign bus_we        = bus_we_q;
  assign ctr_start     = ctr_start_q;
  assign ctr_read_open = read_open_q;
  assign res_valid     = res_valid_q;
  assign cmd_ready     = cmd_ready_q;
  assign busy          = busy_q;
  assign res_count     = count_q;
  assign res_time      = time_q;
  assign res_timeout   = timeout_q;

endmodule
